// File: rtl/wb_arbiter.sv
// Writeback arbiter: four single-entry completion slots (ALU0-2, LSU) drained onto two ports.
// Round-robin by default; define WB_ARB_FIXED_PRIO_EN for fixed priority (slot 0 highest).
module wb_arbiter #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              out_stall,
    input  logic              in_valid_0,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              in_valid_3,
    input  logic [PC_W-1:0]   in_pc_0,
    input  logic [PC_W-1:0]   in_pc_1,
    input  logic [PC_W-1:0]   in_pc_2,
    input  logic [PC_W-1:0]   in_pc_3,
    input  logic [PREG_W-1:0] in_preg_0,
    input  logic [PREG_W-1:0] in_preg_1,
    input  logic [PREG_W-1:0] in_preg_2,
    input  logic [PREG_W-1:0] in_preg_3,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [DATA_W-1:0] in_data_3,
    output logic              in_ready_0,
    output logic              in_ready_1,
    output logic              in_ready_2,
    output logic              in_ready_3,
    output logic              out_valid_0,
    output logic              out_valid_1,
    output logic [PC_W-1:0]   out_pc_0,
    output logic [PC_W-1:0]   out_pc_1,
    output logic [PREG_W-1:0] out_preg_0,
    output logic [PREG_W-1:0] out_preg_1,
    output logic [DATA_W-1:0] out_data_0,
    output logic [DATA_W-1:0] out_data_1
);

    logic [3:0]        in_v, in_rdy, grant, slot_v_q;
    logic [PC_W-1:0]   in_pc   [4];
    logic [PREG_W-1:0] in_preg [4];
    logic [DATA_W-1:0] in_data [4];
    logic [PC_W-1:0]   slot_pc_q   [4];
    logic [PREG_W-1:0] slot_preg_q [4];
    logic [DATA_W-1:0] slot_data_q [4];

    logic              g0_v, g1_v;
    logic [1:0]        g0_idx, g1_idx, scan_start;
    logic [1:0]        out_v_q;
    logic [PC_W-1:0]   out_pc_q   [2];
    logic [PREG_W-1:0] out_preg_q [2];
    logic [DATA_W-1:0] out_data_q [2];

    assign in_v    = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
    assign in_pc   = '{in_pc_0, in_pc_1, in_pc_2, in_pc_3};
    assign in_preg = '{in_preg_0, in_preg_1, in_preg_2, in_preg_3};
    assign in_data = '{in_data_0, in_data_1, in_data_2, in_data_3};

`ifdef WB_ARB_FIXED_PRIO_EN
    assign scan_start = 2'd0;
`else
    logic [1:0] rr_ptr_q;
    assign scan_start = rr_ptr_q;
`endif

    // Grants depend only on registered slot state, so in_ready never sees in_valid.
    always_comb begin
        g0_v   = 1'b0;
        g1_v   = 1'b0;
        g0_idx = 2'd0;
        g1_idx = 2'd0;
        grant  = 4'b0;
        if (!out_stall) begin
            for (int j = 0; j < 4; j++) begin
                if (slot_v_q[scan_start + j[1:0]]) begin
                    if (!g0_v) begin
                        g0_v   = 1'b1;
                        g0_idx = scan_start + j[1:0];
                    end else if (!g1_v) begin
                        g1_v   = 1'b1;
                        g1_idx = scan_start + j[1:0];
                    end
                end
            end
        end
        if (g0_v) grant[g0_idx] = 1'b1;
        if (g1_v) grant[g1_idx] = 1'b1;
    end

    assign in_rdy = ~slot_v_q | grant;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slot_v_q <= 4'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (in_v[i] && in_rdy[i]) slot_v_q[i] <= 1'b1;
                else if (grant[i])        slot_v_q[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_v[i] && in_rdy[i]) begin
                slot_pc_q[i]   <= in_pc[i];
                slot_preg_q[i] <= in_preg[i];
                slot_data_q[i] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q <= 2'b0;
            for (int k = 0; k < 2; k++) begin
                out_pc_q[k]   <= '0;
                out_preg_q[k] <= '0;
                out_data_q[k] <= '0;
            end
`ifndef WB_ARB_FIXED_PRIO_EN
            rr_ptr_q <= 2'd0;
`endif
        end else if (flush) begin
            out_v_q <= 2'b0;
`ifndef WB_ARB_FIXED_PRIO_EN
            rr_ptr_q <= 2'd0;
`endif
        end else begin
            out_v_q <= {g1_v, g0_v};
            if (g0_v) begin
                out_pc_q[0]   <= slot_pc_q[g0_idx];
                out_preg_q[0] <= slot_preg_q[g0_idx];
                out_data_q[0] <= slot_data_q[g0_idx];
            end
            if (g1_v) begin
                out_pc_q[1]   <= slot_pc_q[g1_idx];
                out_preg_q[1] <= slot_preg_q[g1_idx];
                out_data_q[1] <= slot_data_q[g1_idx];
            end
`ifndef WB_ARB_FIXED_PRIO_EN
            if (g0_v) rr_ptr_q <= (g1_v ? g1_idx : g0_idx) + 2'd1;
`endif
        end
    end

    assign {in_ready_3, in_ready_2, in_ready_1, in_ready_0} = in_rdy;
    assign out_valid_0 = out_v_q[0];
    assign out_valid_1 = out_v_q[1];
    assign out_pc_0    = out_pc_q[0];
    assign out_pc_1    = out_pc_q[1];
    assign out_preg_0  = out_preg_q[0];
    assign out_preg_1  = out_preg_q[1];
    assign out_data_0  = out_data_q[0];
    assign out_data_1  = out_data_q[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (round-robin build) with hand-computed expectations.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush, out_stall;
    logic        iv   [4];
    logic [31:0] pc   [4];
    logic [5:0]  preg [4];
    logic [31:0] dat  [4];
    logic        rdy  [4];
    logic        ov0, ov1;
    logic [31:0] opc0, opc1, odat0, odat1;
    logic [5:0]  oprg0, oprg1;
    int          n_tot = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush), .out_stall(out_stall),
        .in_valid_0(iv[0]), .in_valid_1(iv[1]), .in_valid_2(iv[2]), .in_valid_3(iv[3]),
        .in_pc_0(pc[0]), .in_pc_1(pc[1]), .in_pc_2(pc[2]), .in_pc_3(pc[3]),
        .in_preg_0(preg[0]), .in_preg_1(preg[1]), .in_preg_2(preg[2]), .in_preg_3(preg[3]),
        .in_data_0(dat[0]), .in_data_1(dat[1]), .in_data_2(dat[2]), .in_data_3(dat[3]),
        .in_ready_0(rdy[0]), .in_ready_1(rdy[1]), .in_ready_2(rdy[2]), .in_ready_3(rdy[3]),
        .out_valid_0(ov0), .out_valid_1(ov1),
        .out_pc_0(opc0), .out_pc_1(opc1),
        .out_preg_0(oprg0), .out_preg_1(oprg1),
        .out_data_0(odat0), .out_data_1(odat1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a valid mask; payload for requester i derives from base.
    task automatic drive(input logic [3:0] mask, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            iv[i]   = mask[i];
            pc[i]   = base + 32'(i);
            preg[i] = 6'(i + 8);
            dat[i]  = ~(base + 32'(i));
        end
    endtask

    function automatic logic [3:0] rdy_vec();
        return {rdy[3], rdy[2], rdy[1], rdy[0]};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; out_stall = 1'b0;
        drive(4'b0000, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        // idle after reset
        chk("idle_ov", {ov1, ov0}, 2'b00);
        chk("idle_rdy", rdy_vec(), 4'b1111);
        chk("idle_pc", {opc1, opc0}, 64'h0);
        chk("idle_data", {odat1, odat0}, 64'h0);
        chk("idle_preg", {oprg1, oprg0}, 12'h0);

        // single completion on requester 1
        iv[1] = 1'b1; pc[1] = 32'h40; preg[1] = 6'd5; dat[1] = 32'hDEAD;
        tick();
        iv[1] = 1'b0;
        chk("single_early", {ov1, ov0}, 2'b00);
        tick();
        chk("single_ov", {ov1, ov0}, 2'b01);
        chk("single_pc", opc0, 32'h40);
        chk("single_preg", oprg0, 6'd5);
        chk("single_data", odat0, 32'hDEAD);
        tick();
        chk("single_once", {ov1, ov0}, 2'b00);

        // rr_ptr now 2; flush returns it to 0
        flush = 1'b1; tick(); flush = 1'b0;

        // all four valid every cycle: {0,1},{2,3},{0,1}
        drive(4'b1111, 32'h1000);
        tick();
        chk("rr_rdyA", rdy_vec(), 4'b0011);
        drive(4'b1111, 32'h2000);
        tick();
        chk("rr_ovB", {ov1, ov0}, 2'b11);
        chk("rr_pcB", {opc1, opc0}, {32'h1001, 32'h1000});
        chk("rr_dataB", {odat1, odat0}, {~32'h1001, ~32'h1000});
        chk("rr_rdyB", rdy_vec(), 4'b1100);
        drive(4'b1111, 32'h3000);
        tick();
        chk("rr_pcC", {opc1, opc0}, {32'h1003, 32'h1002});
        chk("rr_pregC", {oprg1, oprg0}, {6'd11, 6'd10});
        drive(4'b0000, 32'h0);
        tick();
        chk("rr_pcD", {opc1, opc0}, {32'h2001, 32'h2000});
        flush = 1'b1; tick(); flush = 1'b0;

        // stall with slots 0 and 2 held
        out_stall = 1'b1;
        drive(4'b0101, 32'h5000);
        tick();
        drive(4'b0000, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_ov", {ov1, ov0}, 2'b00);
            chk("stall_rdy", rdy_vec(), 4'b1010);
        end
        out_stall = 1'b0;
        tick();
        chk("unstall_ov", {ov1, ov0}, 2'b11);
        chk("unstall_pc", {opc1, opc0}, {32'h5002, 32'h5000});
        // rr_ptr is now 3

        // flush with three slots held; flush-cycle capture dropped
        out_stall = 1'b1;
        drive(4'b1011, 32'h6000);
        tick();
        chk("preflush_rdy", rdy_vec(), 4'b0100);
        drive(4'b0100, 32'h7000);
        flush = 1'b1;
        tick();
        flush = 1'b0; out_stall = 1'b0;
        drive(4'b0000, 32'h0);
        chk("flush_ov", {ov1, ov0}, 2'b00);
        chk("flush_rdy", rdy_vec(), 4'b1111);
        tick();
        chk("flush_after_ov", {ov1, ov0}, 2'b00);
        // rr_ptr must be 0: slot 1 beats slot 3
        drive(4'b1010, 32'h8000);
        tick();
        drive(4'b0000, 32'h0);
        tick();
        chk("flush_rr_pc", {opc1, opc0}, {32'h8003, 32'h8001});

        // reset while slots held under stall
        out_stall = 1'b1;
        drive(4'b0111, 32'h9000);
        tick();
        drive(4'b0000, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0; out_stall = 1'b0;
        chk("rst_ov", {ov1, ov0}, 2'b00);
        chk("rst_rdy", rdy_vec(), 4'b1111);
        chk("rst_pc", {opc1, opc0}, 64'h0);
        chk("rst_data", {odat1, odat0}, 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_drop_ov", {ov1, ov0}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
